// File: rtl/ocupacao_pkg.sv
// ---------------------------------------------------------------------------
// ocupacao_pkg
// Shared types and constants for the occupancy controller.
//   estado_t          : FSM state encoding (LIVRE, CONFIRMA, OCUPADO, ESPERA)
//   *_CYC_DEF         : default debounce / confirm / hold cycle counts
//   cnt_width()       : bits needed to hold values 0..n-1 (never less than 1)
//   max2()            : larger of two ints, for sizing the shared timer
// ---------------------------------------------------------------------------
package ocupacao_pkg;

  typedef enum logic [1:0] {
    LIVRE    = 2'b00,
    CONFIRMA = 2'b01,
    OCUPADO  = 2'b10,
    ESPERA   = 2'b11
  } estado_t;

  localparam int DEB_CYC_DEF  = 50000;
  localparam int CONF_CYC_DEF = 25000000;
  localparam int HOLD_CYC_DEF = 250000000;

  localparam int CONTAGEM_W = 16;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_sinal.sv
// ---------------------------------------------------------------------------
// debounce_sinal
// Two-flop synchronizer followed by a persistence filter: the output only
// follows the synchronized input after it has differed from the output for
// DEB_CYC consecutive cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   din  : asynchronous raw input
//   dout : synchronized, debounced output
// ---------------------------------------------------------------------------
module debounce_sinal
  import ocupacao_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int            CW       = cnt_width(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        // Any agreement restarts the persistence window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_db;

endmodule

// File: rtl/ocupacao_ctrl.sv
// ---------------------------------------------------------------------------
// ocupacao_ctrl
// Occupancy controller: debounces a presence sensor, confirms entry after
// CONF_CYC cycles of presence, releases after HOLD_CYC cycles of absence,
// and counts confirmed occupations.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   sensor         : raw asynchronous presence sensor (1 = presence)
//   forca_livre    : level-sensitive manual release (1 = force free)
//   ocupado        : 1 in OCUPADO/ESPERA
//   aguardando     : 1 in CONFIRMA/ESPERA
//   evento_entrada : one-cycle pulse on CONFIRMA -> OCUPADO
//   evento_saida   : one-cycle pulse on OCUPADO/ESPERA -> LIVRE
//   contagem       : saturating count of confirmed occupations
// ---------------------------------------------------------------------------
module ocupacao_ctrl
  import ocupacao_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int CONF_CYC = CONF_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sensor,
  input  logic                  forca_livre,
  output logic                  ocupado,
  output logic                  aguardando,
  output logic                  evento_entrada,
  output logic                  evento_saida,
  output logic [CONTAGEM_W-1:0] contagem
);

  localparam int            TW        = cnt_width(max2(CONF_CYC, HOLD_CYC));
  localparam logic [TW-1:0] TMR_MAX   = TW'(max2(CONF_CYC, HOLD_CYC) - 1);
  localparam logic [TW-1:0] CONF_LAST = TW'(CONF_CYC - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);

  logic                  w_sensor_db;
  estado_t               r_estado;
  estado_t               w_estado_next;
  logic [TW-1:0]         r_timer;
  logic [CONTAGEM_W-1:0] r_contagem;
  logic                  r_ev_ent;
  logic                  r_ev_sai;
  logic                  w_ev_ent_next;
  logic                  w_ev_sai_next;

  debounce_sinal #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (sensor),
    .dout (w_sensor_db)
  );

  // State register, shared timer, event registers and occupation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado   <= LIVRE;
      r_timer    <= '0;
      r_contagem <= '0;
      r_ev_ent   <= 1'b0;
      r_ev_sai   <= 1'b0;
    end else begin
      r_estado <= w_estado_next;
      // Timer restarts on each state change; it saturates so long stays in
      // LIVRE/OCUPADO cannot wrap it back into a matching value.
      if (w_estado_next != r_estado) begin
        r_timer <= '0;
      end else if (r_timer != TMR_MAX) begin
        r_timer <= r_timer + 1'b1;
      end
      r_ev_ent <= w_ev_ent_next;
      r_ev_sai <= w_ev_sai_next;
      if (w_ev_ent_next && (r_contagem != {CONTAGEM_W{1'b1}})) begin
        r_contagem <= r_contagem + 1'b1;
      end
    end
  end

  // Next-state logic; manual release overrides every other transition.
  always_comb begin
    w_estado_next = r_estado;
    w_ev_ent_next = 1'b0;
    w_ev_sai_next = 1'b0;
    if (forca_livre) begin
      w_estado_next = LIVRE;
      w_ev_sai_next = (r_estado == OCUPADO) || (r_estado == ESPERA);
    end else begin
      case (r_estado)
        LIVRE: begin
          if (w_sensor_db) w_estado_next = CONFIRMA;
        end
        CONFIRMA: begin
          if (!w_sensor_db) begin
            w_estado_next = LIVRE;
          end else if (r_timer == CONF_LAST) begin
            w_estado_next = OCUPADO;
            w_ev_ent_next = 1'b1;
          end
        end
        OCUPADO: begin
          if (!w_sensor_db) w_estado_next = ESPERA;
        end
        ESPERA: begin
          if (w_sensor_db) begin
            w_estado_next = OCUPADO;
          end else if (r_timer == HOLD_LAST) begin
            w_estado_next = LIVRE;
            w_ev_sai_next = 1'b1;
          end
        end
        default: w_estado_next = LIVRE;
      endcase
    end
  end

  // Outputs decoded purely from registers.
  always_comb begin
    ocupado        = (r_estado == OCUPADO) || (r_estado == ESPERA);
    aguardando     = (r_estado == CONFIRMA) || (r_estado == ESPERA);
    evento_entrada = r_ev_ent;
    evento_saida   = r_ev_sai;
    contagem       = r_contagem;
  end

endmodule

// File: tb/tb_ocupacao_ctrl.sv
module tb_ocupacao_ctrl;

  localparam int DEB  = 4;
  localparam int CONF = 8;
  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        sensor;
  logic        forca_livre;
  logic        ocupado;
  logic        aguardando;
  logic        evento_entrada;
  logic        evento_saida;
  logic [15:0] contagem;

  ocupacao_ctrl #(
    .DEB_CYC  (DEB),
    .CONF_CYC (CONF),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sensor         (sensor),
    .forca_livre    (forca_livre),
    .ocupado        (ocupado),
    .aguardando     (aguardando),
    .evento_entrada (evento_entrada),
    .evento_saida   (evento_saida),
    .contagem       (contagem)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; read at the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cyc;
    int cont;
  } ev_t;

  ev_t q_ent[$];
  int  q_sai[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) chk("schedule", cyc, c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: pops an expectation whenever an event pulse appears.
  always @(negedge clk) begin
    ev_t e;
    int  s;
    if (evento_entrada && evento_saida) chk("events_exclusive", 1, 0);
    if (evento_entrada) begin
      $display("cycle %0d: evento_entrada contagem=%0d", cyc, contagem);
      if (q_ent.size() == 0) begin
        chk("unexpected_entrada", cyc, -1);
      end else begin
        e = q_ent.pop_front();
        chk("entrada_cycle", cyc, e.cyc);
        chk("entrada_contagem", int'(contagem), e.cont);
      end
    end
    if (evento_saida) begin
      $display("cycle %0d: evento_saida", cyc);
      if (q_sai.size() == 0) begin
        chk("unexpected_saida", cyc, -1);
      end else begin
        s = q_sai.pop_front();
        chk("saida_cycle", cyc, s);
      end
    end
  end

  initial begin
    int e, f, l, l2, g, r, bad;
    rst         = 1'b1;
    sensor      = 1'b1;
    forca_livre = 1'b0;

    // Reset held for two edges with sensor high.
    wait_cyc(2);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_aguardando", aguardando, 0);
    chk("rst_ev_ent", evento_entrada, 0);
    chk("rst_ev_sai", evento_saida, 0);
    chk("rst_contagem", int'(contagem), 0);

    // Entry: first sampling edge is the next one.
    e = cyc + 1;
    q_ent.push_back(ev_t'{e + 14, 1});
    rst = 1'b0;
    wait_cyc(e + 5);  chk("entry_agu_e5", aguardando, 0);
    wait_cyc(e + 6);  chk("entry_agu_e6", aguardando, 1);
    wait_cyc(e + 13); chk("entry_agu_e13", aguardando, 1);
                      chk("entry_ocup_e13", ocupado, 0);
    wait_cyc(e + 14); chk("entry_ocup_e14", ocupado, 1);
                      chk("entry_agu_e14", aguardando, 0);
                      chk("entry_cont", int'(contagem), 1);
    wait_cyc(e + 15); chk("entry_pulse_end", evento_entrada, 0);

    // Override from OCUPADO with sensor still present.
    wait_cyc(e + 16);
    f = cyc + 1;
    q_sai.push_back(f);
    q_ent.push_back(ev_t'{f + 9, 2});
    forca_livre = 1'b1;
    wait_cyc(f);
    forca_livre = 1'b0;
    chk("ovr_ocup", ocupado, 0);
    chk("ovr_agu", aguardando, 0);
    chk("ovr_cont_held", int'(contagem), 1);
    wait_cyc(f + 1); chk("ovr_confirma", aguardando, 1);
    wait_cyc(f + 2); chk("ovr_pulse_end", evento_saida, 0);
    wait_cyc(f + 8); chk("ovr_ocup_f8", ocupado, 0);
    wait_cyc(f + 9); chk("ovr_ocup_f9", ocupado, 1);
                     chk("ovr_cont", int'(contagem), 2);

    // Short absence of 10 samples: ESPERA then back to OCUPADO silently.
    wait_cyc(f + 11);
    l = cyc + 1;
    sensor = 1'b0;
    wait_cyc(l + 8);  chk("abs_espera_ocup", ocupado, 1);
                      chk("abs_espera_agu", aguardando, 1);
    wait_cyc(l + 9);
    sensor = 1'b1;
    wait_cyc(l + 16); chk("abs_back_agu", aguardando, 0);
                      chk("abs_back_ocup", ocupado, 1);

    // Sustained absence: release 22 edges after first low sample.
    wait_cyc(l + 20);
    l2 = cyc + 1;
    q_sai.push_back(l2 + 22);
    sensor = 1'b0;
    wait_cyc(l2 + 21); chk("rel_ocup_21", ocupado, 1);
    wait_cyc(l2 + 22); chk("rel_ocup_22", ocupado, 0);
                       chk("rel_cont", int'(contagem), 2);

    // Glitch of three samples in LIVRE must not reach CONFIRMA.
    wait_cyc(l2 + 24);
    g = cyc;
    sensor = 1'b1;
    wait_cyc(g + 3);
    sensor = 1'b0;
    bad = 0;
    for (int i = 4; i <= 14; i++) begin
      wait_cyc(g + i);
      if (aguardando || ocupado) bad++;
    end
    chk("glitch_cycles_active", bad, 0);
    chk("glitch_cont", int'(contagem), 2);

    // Reset in the middle of CONFIRMA (timer = 5).
    wait_cyc(g + 16);
    r = cyc + 1;
    sensor = 1'b1;
    wait_cyc(r + 11);
    chk("midrst_in_confirma", aguardando, 1);
    rst = 1'b1;
    wait_cyc(r + 12);
    chk("midrst_agu", aguardando, 0);
    chk("midrst_ocup", ocupado, 0);
    chk("midrst_cont", int'(contagem), 0);
    chk("midrst_ev_sai", evento_saida, 0);
    wait_cyc(r + 13);
    rst    = 1'b0;
    sensor = 1'b0;
    wait_cyc(r + 30);
    chk("final_ocup", ocupado, 0);
    chk("pending_entrada", q_ent.size(), 0);
    chk("pending_saida", q_sai.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
